// File: rtl/dma_ctl_if.sv
// rtl/dma_ctl_if.sv - CPU register window and DMA bus-master signals of the DMA controller
interface dma_ctl_if;
    logic [2:0]  AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        rw;
    logic        cs;
    logic        irq;
    logic        hold;
    logic        dma_active;
    logic [15:0] dma_ad;
    logic [7:0]  dma_do;
    logic [7:0]  dma_di;
    logic        dma_rw;
    logic        dma_vma;

    modport slave (
        input  AD, DI, rw, cs, dma_di,
        output DO, irq, hold, dma_active, dma_ad, dma_do, dma_rw, dma_vma
    );

    modport master (
        output AD, DI, rw, cs, dma_di,
        input  DO, irq, hold, dma_active, dma_ad, dma_do, dma_rw, dma_vma
    );
endinterface

// File: rtl/dma_ctl.sv
// rtl/dma_ctl.sv - single-channel memory-to-memory DMA controller, 3 bus cycles per byte
module dma_ctl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    dma_ctl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, REQ, RD0, RD1, WR, FIN} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [15:0] src_q, dst_q, cnt_q;
    logic [7:0]  buf_q;
    logic [3:0]  settle_q;
    logic        ie_q, src_fix_q, dst_fix_q, busy_q, done_q;

    logic        cpu_wr, reg_wr, start, stat_wr;
    logic [15:0] cnt_dec;
    logic        hold_c, active_c, vma_c, rw_c;
    logic [15:0] ad_c;
    logic [7:0]  do_c, rd_mux;

    assign cpu_wr  = bus.cs & ~bus.rw;
    assign reg_wr  = cpu_wr & ~busy_q;
    assign start   = reg_wr && (bus.AD == 3'd6) && bus.DI[0];
    assign stat_wr = cpu_wr && (bus.AD == 3'd7);
    assign cnt_dec = cnt_q - 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_c   = 1'b0;
        active_c = 1'b0;
        vma_c    = 1'b0;
        rw_c     = 1'b1;
        ad_c     = 16'h0000;
        do_c     = 8'h00;
        case (state_q)
            IDLE: if (start && (cnt_q != 16'd0)) state_d = REQ;
            REQ: begin
                hold_c = 1'b1;
                if (settle_q == SETTLE_LAST) state_d = RD0;
            end
            RD0, RD1: begin
                hold_c   = 1'b1;
                active_c = 1'b1;
                vma_c    = 1'b1;
                ad_c     = src_q;
                state_d  = (state_q == RD0) ? RD1 : WR;
            end
            WR: begin
                hold_c   = 1'b1;
                active_c = 1'b1;
                vma_c    = 1'b1;
                rw_c     = 1'b0;
                ad_c     = dst_q;
                do_c     = buf_q;
                state_d  = (cnt_dec != 16'd0) ? RD0 : FIN;
            end
            FIN: begin
                hold_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= 16'h0000;
            dst_q     <= 16'h0000;
            cnt_q     <= 16'h0000;
            buf_q     <= 8'h00;
            settle_q  <= 4'd0;
            ie_q      <= 1'b0;
            src_fix_q <= 1'b0;
            dst_fix_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            settle_q <= (state_q == REQ) ? settle_q + 4'd1 : 4'd0;
            if (reg_wr) begin
                case (bus.AD)
                    3'd0: src_q[15:8] <= bus.DI;
                    3'd1: src_q[7:0]  <= bus.DI;
                    3'd2: dst_q[15:8] <= bus.DI;
                    3'd3: dst_q[7:0]  <= bus.DI;
                    3'd4: cnt_q[15:8] <= bus.DI;
                    3'd5: cnt_q[7:0]  <= bus.DI;
                    3'd6: begin
                        ie_q      <= bus.DI[1];
                        src_fix_q <= bus.DI[2];
                        dst_fix_q <= bus.DI[3];
                    end
                    default: ;
                endcase
            end
            if (state_q == RD1) buf_q <= bus.dma_di;
            if (state_q == WR) begin
                cnt_q <= cnt_dec;
                if (!src_fix_q) src_q <= src_q + 16'd1;
                if (!dst_fix_q) dst_q <= dst_q + 16'd1;
            end
            // Later assignments win: a DONE set beats a same-cycle STAT write.
            if (stat_wr) done_q <= 1'b0;
            if (start) begin
                if (cnt_q != 16'd0) begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end else begin
                    done_q <= 1'b1;
                end
            end
            if (state_q == FIN) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (bus.AD)
            3'd0: rd_mux = src_q[15:8];
            3'd1: rd_mux = src_q[7:0];
            3'd2: rd_mux = dst_q[15:8];
            3'd3: rd_mux = dst_q[7:0];
            3'd4: rd_mux = cnt_q[15:8];
            3'd5: rd_mux = cnt_q[7:0];
            3'd6: rd_mux = {4'b0000, dst_fix_q, src_fix_q, ie_q, 1'b0};
            3'd7: rd_mux = {done_q, 6'b000000, busy_q};
            default: rd_mux = 8'h00;
        endcase
    end

    assign bus.DO         = rd_mux;
    assign bus.irq        = done_q & ie_q;
    assign bus.hold       = hold_c;
    assign bus.dma_active = active_c;
    assign bus.dma_vma    = vma_c;
    assign bus.dma_rw     = rw_c;
    assign bus.dma_ad     = ad_c;
    assign bus.dma_do     = do_c;
endmodule
